data_memory_ctrl: RTL and testbench

//  Parametrised data memory with a valid/ready request/response handshake and

---
 rtl/data_memory_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//
// Purpose:
//   Data memory behind a valid/ready request/response handshake. It holds one
//   request at a time and answers it after a fixed number of wait states.
//   Accesses can be byte, half, word or dword wide. Stores write only the
//   addressed byte lanes. Loads zero- or sign-extend the addressed bytes.
//   Misaligned, out-of-range and illegal-size accesses are reported on rsp_err.
//   In the LEGv8 pipeline this block sits between the MEM-stage controller and
//   the word-array storage.
//
// Ports:
//   clk        in   1       clock, all logic on posedge
//   reset      in   1       synchronous, active-high
//   req_valid  in   1       request present
//   req_ready  out  1       controller can accept a request (IDLE only)
//   req_we     in   1       1 = store, 0 = load
//   req_size   in   2       0 = byte, 1 = half, 2 = word, 3 = dword
//   req_signed in   1       sign-extend loads when 1
//   req_addr   in   ADDR_W  byte address, little-endian lanes
//   req_wdata  in   DATA_W  store data, right-justified
//   rsp_valid  out  1       response present
//   rsp_ready  in   1       consumer accepts response
//   rsp_rdata  out  DATA_W  extended load result, 0 for stores and errors
//   rsp_err    out  1       misaligned, out-of-range or illegal size

module data_memory_ctrl #(
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MIDX_W = $clog2(DEPTH);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    // At time zero, word i holds the value i. Reset does not clear the
    // storage, so this declaration initialiser is its only source of
    // initial contents.
    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = DATA_W'(i);
        end
        return m;
    endfunction

    mem_t mem = init_mem();

    state_t state, next_state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              cur_we;
    logic [1:0]        cur_size;
    logic              cur_signed;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [MIDX_W-1:0] midx;
    int                nbytes;
    logic [ADDR_W-1:0] align_mask;
    logic              access_err;
    logic [BYTES-1:0]  byte_en;
    logic [DATA_W-1:0] wshift;
    logic [DATA_W-1:0] rshift;
    logic [DATA_W-1:0] load_val;
    logic              accept;
    logic              enter_resp;

    // With zero wait states the commit happens on the accept edge itself,
    // before the request registers are loaded. Outside IDLE, the captured
    // copy is used so later input changes have no effect.
    always_comb begin
        cur_we     = we_q;
        cur_size   = size_q;
        cur_signed = signed_q;
        cur_addr   = addr_q;
        cur_wdata  = wdata_q;
        if (state == S_IDLE) begin
            cur_we     = req_we;
            cur_size   = req_size;
            cur_signed = req_signed;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata;
        end
    end

    // Address decode and error detection. DEPTH is a power of two, so an index
    // past the end is one with any bit set above the storage index width.
    always_comb begin
        off    = cur_addr[OFF_W-1:0];
        idx    = cur_addr[ADDR_W-1:OFF_W];
        midx   = idx[MIDX_W-1:0];
        nbytes = 1 << cur_size;
        if (nbytes > BYTES) begin
            nbytes = BYTES;
        end
        case (cur_size)
            2'd0:    align_mask = ADDR_W'(0);
            2'd1:    align_mask = ADDR_W'(1);
            2'd2:    align_mask = ADDR_W'(3);
            default: align_mask = ADDR_W'(7);
        endcase
        access_err = ((cur_addr & align_mask) != '0)
                   || ((cur_size == 2'd3) && (DATA_W == 32))
                   || ((idx >> MIDX_W) != '0);
    end

    // Byte-lane write enables and lane-aligned store data. Store data is
    // shifted as a whole, but only the enabled lanes reach storage.
    always_comb begin
        byte_en = '0;
        for (int b = 0; b < BYTES; b++) begin
            byte_en[b] = (b >= int'(off)) && (b < int'(off) + nbytes);
        end
        wshift = cur_wdata << {off, 3'b000};
    end

    // Load path. The addressed bytes move down to bit 0. Bits above the access
    // width take the access MSB when sign-extending, or zero otherwise.
    always_comb begin
        rshift   = mem[midx] >> {off, 3'b000};
        load_val = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < 8 * nbytes) begin
                load_val[i] = rshift[i];
            end else begin
                load_val[i] = cur_signed & rshift[8 * nbytes - 1];
            end
        end
    end

    assign accept     = (state == S_IDLE) && req_valid;
    assign enter_resp = (accept && (WAIT_STATES == 0))
                     || ((state == S_WAIT) && (cnt == 4'd0));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A retiring RESP goes back to IDLE, so req_ready stays
    // low during the retire cycle.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    next_state = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
    end

    // Request capture, wait counter and the response registers. The response
    // registers are written only when RESP is entered, which keeps them stable
    // under back-pressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= 4'd0;
            we_q     <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                cnt      <= WS_LOAD;
            end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                err_q   <= access_err;
                rdata_q <= (access_err || cur_we) ? '0 : load_val;
            end
        end
    end

    // Storage write on the edge that enters RESP. A reset in WAIT therefore
    // drops the store. A store that has already reached RESP is kept.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && cur_we && !access_err) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byte_en[b]) begin
                    mem[midx][8*b +: 8] <= wshift[8*b +: 8];
                end
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl
//
// Purpose:
//   Directed self-checking bench for data_memory_ctrl. The main instance uses
//   DATA_W=64 with one wait state. A second instance uses three wait states
//   and covers reset in the middle of an operation. Every expected value is
//   worked out by hand from the initial contents (word i = i) and the stores
//   made earlier in the run.
//
// Ports: none (top-level bench).

module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    logic        reset3;
    logic        req_valid3;
    logic        req_ready3;
    logic        req_we3;
    logic [1:0]  req_size3;
    logic        req_signed3;
    logic [15:0] req_addr3;
    logic [63:0] req_wdata3;
    logic        rsp_valid3;
    logic        rsp_ready3;
    logic [63:0] rsp_rdata3;
    logic        rsp_err3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(
        .DATA_W(64), .DEPTH(256), .ADDR_W(16), .WAIT_STATES(1)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_memory_ctrl #(
        .DATA_W(64), .DEPTH(256), .ADDR_W(16), .WAIT_STATES(3)
    ) dut3 (
        .clk(clk), .reset(reset3),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3),
        .req_size(req_size3), .req_signed(req_signed3), .req_addr(req_addr3),
        .req_wdata(req_wdata3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
    );

    // One complete access on the main instance. Inputs are driven 1 time unit
    // after a posedge. After the accept they are scrambled, which shows that
    // the request was captured. lat counts edges from the handshake cycle to
    // the first cycle with rsp_valid high.
    task automatic do_access(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [15:0] addr, input logic [63:0] wdata,
                             output logic [63:0] rdata, output logic err, output int lat);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        rsp_ready  = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_size   = ~size;
        req_signed = ~sgn;
        req_addr   = 16'h5A5A;
        req_wdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
        end
        checks++;
        if (rsp_rdata !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata);
        end
        checks++;
        if (rsp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err);
        end
    endtask

    task automatic test_load_latency();
        logic [63:0] d;
        logic        e;
        int          l;
        do_access(1'b0, 2'd3, 1'b0, 16'h0018, 64'h0, d, e, l);
        checks++;
        if (l !== 2) begin
            errors++;
            $display("[TB] FAIL load_latency: got %0d expected 2", l);
        end
        checks++;
        if (d !== 64'd3) begin
            errors++;
            $display("[TB] FAIL load_0x18_data: got %h expected 3", d);
        end
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_0x18_err: got %b expected 0", e);
        end
    endtask

    task automatic test_byte_store();
        logic [63:0] d;
        logic        e;
        int          l;
        do_access(1'b1, 2'd0, 1'b0, 16'h0021, 64'h1234_5678_9ABC_DEAB, d, e, l);
        checks++;
        if (d !== 64'h0 || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL byte_store_rsp: got data %h err %b expected 0 0", d, e);
        end
        do_access(1'b0, 2'd3, 1'b0, 16'h0020, 64'h0, d, e, l);
        checks++;
        if (d !== 64'h0000_0000_0000_AB04) begin
            errors++;
            $display("[TB] FAIL byte_store_readback: got %h expected 000000000000ab04", d);
        end
        do_access(1'b0, 2'd0, 1'b0, 16'h0021, 64'h0, d, e, l);
        checks++;
        if (d !== 64'h0000_0000_0000_00AB) begin
            errors++;
            $display("[TB] FAIL byte_load_unsigned: got %h expected 00000000000000ab", d);
        end
        do_access(1'b0, 2'd0, 1'b1, 16'h0021, 64'h0, d, e, l);
        checks++;
        if (d !== 64'hFFFF_FFFF_FFFF_FFAB) begin
            errors++;
            $display("[TB] FAIL byte_load_signed: got %h expected ffffffffffffffab", d);
        end
    endtask

    task automatic test_half_word();
        logic [63:0] d;
        logic        e;
        int          l;
        do_access(1'b1, 2'd1, 1'b0, 16'h0030, 64'hCCCC_CCCC_CCCC_8001, d, e, l);
        do_access(1'b0, 2'd1, 1'b1, 16'h0030, 64'h0, d, e, l);
        checks++;
        if (d !== 64'hFFFF_FFFF_FFFF_8001) begin
            errors++;
            $display("[TB] FAIL half_load_signed: got %h expected ffffffffffff8001", d);
        end
        do_access(1'b0, 2'd1, 1'b0, 16'h0030, 64'h0, d, e, l);
        checks++;
        if (d !== 64'h0000_0000_0000_8001) begin
            errors++;
            $display("[TB] FAIL half_load_unsigned: got %h expected 0000000000008001", d);
        end
        do_access(1'b0, 2'd2, 1'b1, 16'h0030, 64'h0, d, e, l);
        checks++;
        if (d !== 64'h0000_0000_0000_8001) begin
            errors++;
            $display("[TB] FAIL word_load_signed_pos: got %h expected 0000000000008001", d);
        end
        do_access(1'b0, 2'd0, 1'b1, 16'h0031, 64'h0, d, e, l);
        checks++;
        if (d !== 64'hFFFF_FFFF_FFFF_FF80) begin
            errors++;
            $display("[TB] FAIL byte_load_signed_0x31: got %h expected ffffffffffffff80", d);
        end
        do_access(1'b1, 2'd3, 1'b0, 16'h0028, 64'h0123_4567_89AB_CDEF, d, e, l);
        do_access(1'b0, 2'd2, 1'b0, 16'h002C, 64'h0, d, e, l);
        checks++;
        if (d !== 64'h0000_0000_0123_4567) begin
            errors++;
            $display("[TB] FAIL word_load_upper: got %h expected 0000000001234567", d);
        end
        do_access(1'b0, 2'd1, 1'b1, 16'h002E, 64'h0, d, e, l);
        checks++;
        if (d !== 64'h0000_0000_0000_0123) begin
            errors++;
            $display("[TB] FAIL half_load_top_lane: got %h expected 0000000000000123", d);
        end
    endtask

    task automatic test_errors();
        logic [63:0] d;
        logic        e;
        int          l;
        do_access(1'b1, 2'd2, 1'b0, 16'h0032, 64'h1122_3344, d, e, l);
        checks++;
        if (e !== 1'b1 || d !== 64'h0) begin
            errors++;
            $display("[TB] FAIL misaligned_store: got err %b data %h expected 1 0", e, d);
        end
        do_access(1'b0, 2'd3, 1'b0, 16'h0030, 64'h0, d, e, l);
        checks++;
        if (d !== 64'h0000_0000_0000_8001 || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misaligned_suppressed: got %h err %b expected 0000000000008001 0", d, e);
        end
        do_access(1'b0, 2'd3, 1'b0, 16'h0800, 64'h0, d, e, l);
        checks++;
        if (e !== 1'b1 || d !== 64'h0) begin
            errors++;
            $display("[TB] FAIL range_load: got err %b data %h expected 1 0", e, d);
        end
        do_access(1'b1, 2'd3, 1'b0, 16'h0800, 64'hFFFF_FFFF_FFFF_FFFF, d, e, l);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("[TB] FAIL range_store_err: got %b expected 1", e);
        end
        do_access(1'b0, 2'd3, 1'b0, 16'h0000, 64'h0, d, e, l);
        checks++;
        if (d !== 64'h0 || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL range_store_suppressed: got %h err %b expected 0 0", d, e);
        end
        do_access(1'b0, 2'd1, 1'b0, 16'h0021, 64'h0, d, e, l);
        checks++;
        if (e !== 1'b1 || d !== 64'h0) begin
            errors++;
            $display("[TB] FAIL misaligned_half_load: got err %b data %h expected 1 0", e, d);
        end
        do_access(1'b0, 2'd3, 1'b0, 16'h07F8, 64'h0, d, e, l);
        checks++;
        if (e !== 1'b0 || d !== 64'd255) begin
            errors++;
            $display("[TB] FAIL last_word_load: got err %b data %h expected 0 ff", e, d);
        end
    endtask

    task automatic test_backpressure();
        int guard;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'd3;
        req_signed = 1'b0;
        req_addr   = 16'h0020;
        rsp_ready  = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = 16'h0000;
        guard = 0;
        while (!rsp_valid && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_handshake cycle %0d: got valid %b ready %b expected 1 0",
                         c, rsp_valid, req_ready);
            end
            checks++;
            if (rsp_rdata !== 64'h0000_0000_0000_AB04) begin
                errors++;
                $display("[TB] FAIL stall_data cycle %0d: got %h expected 000000000000ab04", c, rsp_rdata);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_retire: got valid %b ready %b expected 0 1", rsp_valid, req_ready);
        end
    endtask

    // Runs on the three-wait-state instance: reset during a store's WAIT,
    // reset while a store's response is held in RESP, and a load whose
    // latency is measured.
    task automatic test_reset_mid_op();
        int l;
        req_valid3  = 1'b1;
        req_we3     = 1'b1;
        req_size3   = 2'd3;
        req_signed3 = 1'b0;
        req_addr3   = 16'h0040;
        req_wdata3  = 64'hDEAD_BEEF_CAFE_F00D;
        rsp_ready3  = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        reset3     = 1'b1;
        @(posedge clk); #1;
        reset3 = 1'b0;
        checks++;
        if (req_ready3 !== 1'b1 || rsp_valid3 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_reset_state: got ready %b valid %b expected 1 0", req_ready3, rsp_valid3);
        end

        req_valid3 = 1'b1;
        req_we3    = 1'b1;
        req_addr3  = 16'h0048;
        req_wdata3 = 64'h1122_3344_5566_7788;
        rsp_ready3 = 1'b0;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        l = 1;
        while (!rsp_valid3 && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
        reset3 = 1'b1;
        @(posedge clk); #1;
        reset3     = 1'b0;
        rsp_ready3 = 1'b1;
        checks++;
        if (rsp_valid3 !== 1'b0 || req_ready3 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL resp_reset_state: got valid %b ready %b expected 0 1", rsp_valid3, req_ready3);
        end

        req_valid3 = 1'b1;
        req_we3    = 1'b0;
        req_addr3  = 16'h0040;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        req_addr3  = 16'h0048;
        l = 1;
        while (!rsp_valid3 && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
        checks++;
        if (l !== 4) begin
            errors++;
            $display("[TB] FAIL ws3_latency: got %0d expected 4", l);
        end
        checks++;
        if (rsp_rdata3 !== 64'd8 || rsp_err3 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_reset_dropped: got %h err %b expected 8 0", rsp_rdata3, rsp_err3);
        end
        @(posedge clk); #1;

        req_valid3 = 1'b1;
        req_addr3  = 16'h0048;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        l = 1;
        while (!rsp_valid3 && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
        checks++;
        if (rsp_rdata3 !== 64'h1122_3344_5566_7788) begin
            errors++;
            $display("[TB] FAIL resp_reset_kept: got %h expected 1122334455667788", rsp_rdata3);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset       = 1'b1;
        reset3      = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_size    = 2'd0;
        req_signed  = 1'b0;
        req_addr    = 16'h0;
        req_wdata   = 64'h0;
        rsp_ready   = 1'b1;
        req_valid3  = 1'b0;
        req_we3     = 1'b0;
        req_size3   = 2'd0;
        req_signed3 = 1'b0;
        req_addr3   = 16'h0;
        req_wdata3  = 64'h0;
        rsp_ready3  = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        reset  = 1'b0;
        reset3 = 1'b0;

        test_reset();
        test_load_latency();
        test_byte_store();
        test_half_word();
        test_errors();
        test_backpressure();
        test_reset_mid_op();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
